// File: rtl/ekf_pkg.sv
// Shared constants for the EKF-SLAM command path: stage codes, one-hot stage
// requests and the sequencer state encoding.
package ekf_pkg;

   localparam logic [1:0] STG_PREDICT = 2'd0;
   localparam logic [1:0] STG_NEWLM   = 2'd1;
   localparam logic [1:0] STG_UPDATE  = 2'd2;
   localparam logic [1:0] STG_ILLEGAL = 2'd3;

   localparam logic [2:0] SV_PREDICT  = 3'b001;
   localparam logic [2:0] SV_NEWLM    = 3'b010;
   localparam logic [2:0] SV_UPDATE   = 3'b100;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_ISSUE     = 2'd1;
   localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
   localparam logic [1:0] ST_WAIT_DONE = 2'd3;

   function automatic logic [2:0] stage_onehot(input logic [1:0] stg);
      case (stg)
         STG_PREDICT: return SV_PREDICT;
         STG_NEWLM:   return SV_NEWLM;
         STG_UPDATE:  return SV_UPDATE;
         default:     return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/ekf_stage_sequencer_if.sv
// PS command port and core stage handshake of the EKF stage sequencer.
// Operands are raw bit patterns here; the core interprets them as signed.
interface ekf_stage_sequencer_if #(parameter int DW = 32);

   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_stage;
   logic [DW-1:0] cmd_op0;
   logic [DW-1:0] cmd_op1;
   logic [2:0]    stage_val;
   logic [2:0]    stage_rdy;
   logic [DW-1:0] vlr;
   logic [DW-1:0] alpha;
   logic [DW-1:0] rk;
   logic [DW-1:0] phi;

   modport master (
      output cmd_valid, cmd_stage, cmd_op0, cmd_op1, stage_rdy,
      input  cmd_ready, stage_val, vlr, alpha, rk, phi
   );

   modport slave (
      input  cmd_valid, cmd_stage, cmd_op0, cmd_op1, stage_rdy,
      output cmd_ready, stage_val, vlr, alpha, rk, phi
   );

endinterface

// File: rtl/ekf_cmd_fifo.sv
// Synchronous command FIFO; the head entry is read straight from the register
// array so it is valid in the same cycle the FIFO becomes non-empty.
module ekf_cmd_fifo #(
   parameter int W  = 66,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   output logic [W-1:0]  rd_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);

   localparam int DEPTH = 1 << AW;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          push, pop;

   assign full    = level_q[AW];
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign push    = wr_en & ~full;
   assign pop     = rd_en & ~empty;
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // Data words need no reset: the level count alone defines what is valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
      mem_q <= mem_d;
   end

endmodule

// File: rtl/ekf_stage_sequencer.sv
// Replays buffered predict/newlm/update commands onto the core stage handshake,
// holding operands stable for the whole stage and guarding it with a watchdog.
//   state        | meaning
//   ST_IDLE      | pop next command, load its operand pair
//   ST_ISSUE     | stage_val asserted until core accepts with stage_rdy[s]
//   ST_WAIT_BUSY | waiting for core to drop stage_rdy[s] (stage started)
//   ST_WAIT_DONE | waiting for stage_rdy[s] to return (stage complete)
module ekf_stage_sequencer
   import ekf_pkg::*;
#(
   parameter int DW        = 32,
   parameter int FIFO_AW   = 3,
   parameter int TIMEOUT_W = 16
) (
   input  logic                 clk,
   input  logic                 sys_rst,
   ekf_stage_sequencer_if.slave bus,
   input  logic                 err_clr,
   output logic                 busy,
   output logic [FIFO_AW:0]     fifo_level,
   output logic [15:0]          done_cnt,
   output logic                 err_illegal,
   output logic                 err_timeout
);

   localparam int FW = 2 + 2*DW;
   // Last count before the limit, so a stage occupies at most 2**TIMEOUT_W-1 cycles.
   localparam logic [TIMEOUT_W-1:0] WDOG_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

   logic [1:0]           state_q, state_d;
   logic [1:0]           stg_q, stg_d;
   logic [2:0]           stage_val_q, stage_val_d;
   logic [DW-1:0]        vlr_q, vlr_d, alpha_q, alpha_d, rk_q, rk_d, phi_q, phi_d;
   logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
   logic [15:0]          done_cnt_q, done_cnt_d;
   logic                 err_illegal_q, err_illegal_d, err_timeout_q, err_timeout_d;

   logic          fifo_wr, fifo_rd, fifo_full, fifo_empty, illegal_push, rdy_s, timeout;
   logic [FW-1:0] fifo_wdata, fifo_rdata;
   logic [1:0]    head_stg;

   assign fifo_wdata   = {bus.cmd_stage, bus.cmd_op0, bus.cmd_op1};
   assign fifo_wr      = bus.cmd_valid & (bus.cmd_stage != STG_ILLEGAL);
   assign illegal_push = bus.cmd_valid & ~fifo_full & (bus.cmd_stage == STG_ILLEGAL);
   assign head_stg     = fifo_rdata[FW-1 -: 2];
   assign rdy_s        = |(bus.stage_rdy & stage_onehot(stg_q));

   ekf_cmd_fifo #(.W(FW), .AW(FIFO_AW)) u_fifo (
      .clk     (clk),
      .rst     (sys_rst),
      .wr_en   (fifo_wr),
      .wr_data (fifo_wdata),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   always_comb begin
      state_d     = state_q;
      stg_d       = stg_q;
      stage_val_d = stage_val_q;
      vlr_d       = vlr_q;
      alpha_d     = alpha_q;
      rk_d        = rk_q;
      phi_d       = phi_q;
      wdog_d      = wdog_q;
      done_cnt_d  = done_cnt_q;
      fifo_rd     = 1'b0;
      timeout     = 1'b0;
      if (state_q != ST_IDLE) wdog_d = wdog_q + 1'b1;
      case (state_q)
         ST_IDLE: if (!fifo_empty) begin
            fifo_rd = 1'b1;
            stg_d   = head_stg;
            wdog_d  = '0;
            state_d = ST_ISSUE;
            if (head_stg == STG_PREDICT) begin
               vlr_d   = fifo_rdata[2*DW-1 -: DW];
               alpha_d = fifo_rdata[DW-1:0];
            end else begin
               rk_d  = fifo_rdata[2*DW-1 -: DW];
               phi_d = fifo_rdata[DW-1:0];
            end
         end
         ST_ISSUE: begin
            if ((stage_val_q != 3'b000) && rdy_s) begin
               stage_val_d = 3'b000;
               state_d     = ST_WAIT_BUSY;
            end else begin
               stage_val_d = stage_onehot(stg_q);
            end
         end
         ST_WAIT_BUSY: if (!rdy_s) state_d = ST_WAIT_DONE;
         ST_WAIT_DONE: if (rdy_s) begin
            state_d    = ST_IDLE;
            done_cnt_d = done_cnt_q + 16'd1;
         end
         default: state_d = ST_IDLE;
      endcase
      // Watchdog overrides any handshake progress in the same cycle.
      if ((state_q != ST_IDLE) && (wdog_q == WDOG_LAST)) begin
         timeout     = 1'b1;
         state_d     = ST_IDLE;
         stage_val_d = 3'b000;
         done_cnt_d  = done_cnt_q;
      end
      err_illegal_d = illegal_push | (err_illegal_q & ~err_clr);
      err_timeout_d = timeout | (err_timeout_q & ~err_clr);
   end

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state_q       <= ST_IDLE;
         stg_q         <= '0;
         stage_val_q   <= '0;
         vlr_q         <= '0;
         alpha_q       <= '0;
         rk_q          <= '0;
         phi_q         <= '0;
         wdog_q        <= '0;
         done_cnt_q    <= '0;
         err_illegal_q <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         stg_q         <= stg_d;
         stage_val_q   <= stage_val_d;
         vlr_q         <= vlr_d;
         alpha_q       <= alpha_d;
         rk_q          <= rk_d;
         phi_q         <= phi_d;
         wdog_q        <= wdog_d;
         done_cnt_q    <= done_cnt_d;
         err_illegal_q <= err_illegal_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   assign bus.cmd_ready = ~fifo_full;
   assign bus.stage_val = stage_val_q;
   assign bus.vlr       = vlr_q;
   assign bus.alpha     = alpha_q;
   assign bus.rk        = rk_q;
   assign bus.phi       = phi_q;
   assign busy          = (state_q != ST_IDLE) | ~fifo_empty;
   assign done_cnt      = done_cnt_q;
   assign err_illegal   = err_illegal_q;
   assign err_timeout   = err_timeout_q;

endmodule

// File: tb/tb_ekf_stage_sequencer.sv
// Bench for ekf_stage_sequencer: random command streams against a queue-based
// reference model, plus a second instance with a short watchdog.
module tb_ekf_stage_sequencer;

   localparam int DW    = 32;
   localparam int AW    = 3;
   localparam int DEPTH = 1 << AW;
   localparam int WD_W  = 4;

   typedef struct packed {
      logic [1:0]  stg;
      logic [31:0] op0;
      logic [31:0] op1;
   } cmd_t;

   logic clk = 1'b0;
   logic sys_rst = 1'b1;
   logic err_clr = 1'b0;
   always #5 clk = ~clk;

   ekf_stage_sequencer_if #(.DW(DW)) bus ();
   ekf_stage_sequencer_if #(.DW(DW)) bus_wd ();

   logic        busy, err_illegal, err_timeout;
   logic [AW:0] fifo_level;
   logic [15:0] done_cnt;
   logic        busy_wd, err_illegal_wd, err_timeout_wd;
   logic [AW:0] fifo_level_wd;
   logic [15:0] done_cnt_wd;

   ekf_stage_sequencer #(.DW(DW), .FIFO_AW(AW), .TIMEOUT_W(16)) dut (
      .clk(clk), .sys_rst(sys_rst), .bus(bus.slave), .err_clr(err_clr),
      .busy(busy), .fifo_level(fifo_level), .done_cnt(done_cnt),
      .err_illegal(err_illegal), .err_timeout(err_timeout)
   );

   ekf_stage_sequencer #(.DW(DW), .FIFO_AW(AW), .TIMEOUT_W(WD_W)) dut_wd (
      .clk(clk), .sys_rst(sys_rst), .bus(bus_wd.slave), .err_clr(1'b0),
      .busy(busy_wd), .fifo_level(fifo_level_wd), .done_cnt(done_cnt_wd),
      .err_illegal(err_illegal_wd), .err_timeout(err_timeout_wd)
   );

   int n_checks = 0;
   int n_fail   = 0;

   cmd_t        m_q[$];
   logic [31:0] m_vlr = '0, m_alpha = '0, m_rk = '0, m_phi = '0;
   int          m_done = 0;
   logic        m_err_ill = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_ops(input string tag);
      chk({tag, ".vlr"},   bus.vlr,   m_vlr);
      chk({tag, ".alpha"}, bus.alpha, m_alpha);
      chk({tag, ".rk"},    bus.rk,    m_rk);
      chk({tag, ".phi"},   bus.phi,   m_phi);
   endtask

   // Presents one command for one edge; the model records it only if it expects acceptance.
   task automatic push(input logic [1:0] stg, input logic [31:0] a, input logic [31:0] b,
                       input bit exp_ready);
      bus.cmd_valid = 1'b1;
      bus.cmd_stage = stg;
      bus.cmd_op0   = a;
      bus.cmd_op1   = b;
      chk("cmd_ready", bus.cmd_ready, exp_ready);
      if (exp_ready) begin
         if (stg == 2'd3) m_err_ill = 1'b1;
         else m_q.push_back('{stg, a, b});
      end
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   // Plays the core for the next expected stage; exp_wait<0 means issue time is not checked.
   task automatic run_stage(input int exp_wait, input int lat);
      cmd_t       c;
      int         n;
      logic [2:0] oh;
      c  = m_q.pop_front();
      oh = 3'b001 << c.stg;
      if (c.stg == 2'd0) begin
         m_vlr = c.op0; m_alpha = c.op1;
      end else begin
         m_rk = c.op0; m_phi = c.op1;
      end
      n = 0;
      while (bus.stage_val == 3'b000 && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (exp_wait >= 0) chk("issue_wait", n, exp_wait);
      else chk("issue_seen", (n < 64), 1);
      chk("stage_val", bus.stage_val, oh);
      chk_ops("ops_issue");
      bus.stage_rdy = 3'($urandom) | oh;
      @(negedge clk);
      chk("val_drop", bus.stage_val, 3'b000);
      bus.stage_rdy = 3'($urandom) & ~oh;
      repeat (lat) begin
         @(negedge clk);
         bus.stage_rdy = 3'($urandom) & ~oh;
      end
      chk("busy_mid", busy, 1);
      chk_ops("ops_hold");
      chk("done_hold", done_cnt, 16'(m_done));
      bus.stage_rdy = 3'($urandom) | oh;
      @(negedge clk);
      m_done++;
      chk("done_cnt", done_cnt, 16'(m_done));
      bus.stage_rdy = 3'b000;
   endtask

   initial begin
      #500000;
      $display("FAIL tb_time_limit checks=%0d", n_checks);
      $fatal(1);
   end

   initial begin
      int          n, legal;
      logic [1:0]  s;
      logic [31:0] a, b, c, d;
      logic [2:0]  oh;

      bus.cmd_valid = 0; bus.cmd_stage = 0; bus.cmd_op0 = 0; bus.cmd_op1 = 0; bus.stage_rdy = 0;
      bus_wd.cmd_valid = 0; bus_wd.cmd_stage = 0; bus_wd.cmd_op0 = 0; bus_wd.cmd_op1 = 0;
      bus_wd.stage_rdy = 0;
      repeat (3) @(negedge clk);
      sys_rst = 1'b0;

      // reset state
      chk("rst_stage_val", bus.stage_val, 0);
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      chk("rst_level", fifo_level, 0);
      chk("rst_done", done_cnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_errs", {err_illegal, err_timeout}, 0);
      chk_ops("rst_ops");

      // single predict with fixed operands, core busy for 3 cycles
      push(2'd0, 32'h0001_0000, 32'h0000_8000, 1);
      run_stage(2, 3);
      chk("t1_busy_idle", busy, 0);

      // update after predict: predict pair must survive the update load
      push(2'd0, $urandom, $urandom, 1);
      push(2'd2, $urandom, $urandom, 1);
      run_stage(-1, 2);
      run_stage(2, 1);

      // illegal stage, then clear racing a new illegal, then plain clear
      push(2'd3, $urandom, $urandom, 1);
      chk("t4_level", fifo_level, 0);
      chk("t4_err", err_illegal, m_err_ill);
      chk("t4_busy", busy, 0);
      err_clr = 1'b1;
      push(2'd3, $urandom, $urandom, 1);
      err_clr = 1'b0;
      chk("t4_err_wins", err_illegal, 1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      m_err_ill = 1'b0;
      chk("t4_err_clr", err_illegal, m_err_ill);

      // burst with core stalled: one command held by the FSM plus DEPTH buffered
      for (int k = 1; k <= DEPTH + 2; k++)
         push(2'($urandom_range(0, 2)), $urandom, $urandom, (k <= DEPTH + 1));
      chk("t2_level", fifo_level, DEPTH);
      chk("t2_ready_low", bus.cmd_ready, 0);
      for (int i = 0; i <= DEPTH; i++)
         run_stage((i == 0) ? -1 : 2, $urandom_range(1, 4));
      chk("t2_busy_idle", busy, 0);

      // randomized rounds mixing all stage codes
      for (int r = 0; r < 8; r++) begin
         n = $urandom_range(1, DEPTH);
         legal = 0;
         for (int i = 0; i < n; i++) begin
            s = 2'($urandom_range(0, 3));
            push(s, $urandom, $urandom, 1);
            if (s != 2'd3) legal++;
         end
         @(negedge clk);
         chk("rnd_level", fifo_level, (legal > 0) ? legal - 1 : 0);
         chk("rnd_illegal", err_illegal, m_err_ill);
         err_clr = 1'b1;
         @(negedge clk);
         err_clr = 1'b0;
         m_err_ill = 1'b0;
         for (int i = 0; i < legal; i++)
            run_stage((i == 0) ? -1 : 2, $urandom_range(1, 4));
         chk("rnd_busy_idle", busy, 0);
         chk("rnd_no_timeout", err_timeout, 0);
      end

      // reset while in WAIT_DONE with three commands queued
      for (int i = 0; i < 4; i++) push(2'($urandom_range(0, 2)), $urandom, $urandom, 1);
      n = 0;
      while (bus.stage_val == 3'b000 && n < 64) begin
         @(negedge clk);
         n++;
      end
      oh = 3'b001 << m_q[0].stg;
      chk("t6_issued", bus.stage_val, oh);
      bus.stage_rdy = oh;
      @(negedge clk);
      bus.stage_rdy = 3'b000;
      @(negedge clk);
      chk("t6_level_before", fifo_level, 3);
      sys_rst = 1'b1;
      @(negedge clk);
      sys_rst = 1'b0;
      m_q.delete();
      m_vlr = '0; m_alpha = '0; m_rk = '0; m_phi = '0;
      m_done = 0;
      chk("t6_stage_val", bus.stage_val, 0);
      chk("t6_level", fifo_level, 0);
      chk("t6_done", done_cnt, 0);
      chk("t6_busy", busy, 0);
      chk("t6_ready", bus.cmd_ready, 1);
      chk_ops("t6_ops");
      push(2'($urandom_range(0, 2)), $urandom, $urandom, 1);
      run_stage(2, 2);

      // watchdog instance: core never drops rdy after the handshake
      a = $urandom; b = $urandom; c = $urandom; d = $urandom;
      bus_wd.stage_rdy = 3'b111;
      chk("t5_ready", bus_wd.cmd_ready, 1);
      bus_wd.cmd_valid = 1'b1; bus_wd.cmd_stage = 2'd0;
      bus_wd.cmd_op0 = a; bus_wd.cmd_op1 = b;
      @(negedge clk);
      bus_wd.cmd_op0 = c; bus_wd.cmd_op1 = d;
      @(negedge clk);
      bus_wd.cmd_valid = 1'b0;
      // now one cycle past ISSUE entry of the first command
      chk("t5_vlr_first", bus_wd.vlr, a);
      n = 0;
      while (!err_timeout_wd && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("t5_timeout_cycles", n, (1 << WD_W) - 1);
      chk("t5_stage_val_off", bus_wd.stage_val, 0);
      chk("t5_done_none", done_cnt_wd, 0);
      chk("t5_level_kept", fifo_level_wd, 1);
      @(negedge clk);
      chk("t5_gap", bus_wd.stage_val, 0);
      @(negedge clk);
      chk("t5_next_issue", bus_wd.stage_val, 3'b001);
      chk("t5_vlr_next", bus_wd.vlr, c);
      chk("t5_alpha_next", bus_wd.alpha, d);
      chk("t5_err_sticky", err_timeout_wd, 1);
      chk("t5_other", {err_illegal_wd, busy_wd, bus_wd.rk, bus_wd.phi}, {1'b0, 1'b1, 64'd0});

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
